// File: rtl/lane_input_judge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lane_input_judge                                                       |
// | Judges one synchronised key press against a target lane in a window.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module lane_input_judge #(
  parameter int NUM_LANES     = 4,
  parameter int CODE_W        = 3,
  parameter int WINDOW_CYCLES = 16,
  parameter int SCORE_W       = 8,
  parameter int EMPTY_PENALTY = 0
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 check_input_go,
  input  logic [NUM_LANES-1:0] key_n,
  input  logic [CODE_W-1:0]    line_code,
  output logic                 check_input_done,
  output logic                 correct,
  output logic                 incorrect,
  output logic                 miss,
  output logic [SCORE_W-1:0]   hit_count,
  output logic [SCORE_W-1:0]   streak
);

  localparam int               CNT_W      = $clog2(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_WINDOW = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CODE_W-1:0]    r_code;
  logic                 r_correct;
  logic                 r_incorrect;
  logic                 r_miss;
  logic [NUM_LANES-1:0] r_sync1;
  logic [NUM_LANES-1:0] r_sync2;
  logic [NUM_LANES-1:0] r_prev;

  logic [NUM_LANES-1:0] w_target;
  logic [NUM_LANES-1:0] w_press;
  logic                 w_any_press;
  logic                 w_wrong_press;
  logic                 w_has_target;
  logic                 w_expired;

  // Keys idle high, so the synchroniser and edge history release to ones.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Lane k sits on key bit NUM_LANES-k; out-of-range codes give an empty row.
  always_comb begin
    w_target = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      if (r_code == CODE_W'(k)) w_target[NUM_LANES-k] = 1'b1;
    end
  end

  assign w_press       = r_prev & ~r_sync2;
  assign w_any_press   = |w_press;
  assign w_wrong_press = |(w_press & ~w_target);
  assign w_has_target  = |w_target;
  assign w_expired     = (r_cnt == c_last_cnt);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_code      <= '0;
      r_correct   <= 1'b0;
      r_incorrect <= 1'b0;
      r_miss      <= 1'b0;
    end else if (!check_input_go) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_correct   <= 1'b0;
      r_incorrect <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_ARM;
          r_code  <= line_code;
          r_cnt   <= '0;
        end
        S_ARM: begin
          r_state <= S_WINDOW;
        end
        S_WINDOW: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_any_press || w_expired) begin
            r_state     <= S_DONE;
            r_correct   <= w_has_target && w_any_press && !w_wrong_press;
            r_incorrect <= w_any_press &&
                           (w_has_target ? w_wrong_press : (EMPTY_PENALTY != 0));
            r_miss      <= w_has_target && !w_any_press;
          end
        end
        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

  // Result flags and scores register once, on the first DONE cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      check_input_done <= 1'b0;
      correct          <= 1'b0;
      incorrect        <= 1'b0;
      miss             <= 1'b0;
      hit_count        <= '0;
      streak           <= '0;
    end else if (!check_input_go) begin
      check_input_done <= 1'b0;
      correct          <= 1'b0;
      incorrect        <= 1'b0;
      miss             <= 1'b0;
    end else if ((r_state == S_DONE) && !check_input_done) begin
      check_input_done <= 1'b1;
      correct          <= r_correct;
      incorrect        <= r_incorrect;
      miss             <= r_miss;
      if (r_correct) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
        if (streak != '1)    streak    <= streak + 1'b1;
      end else if (r_incorrect || r_miss) begin
        streak <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_input_judge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lane_input_judge                                                    |
// | Scoreboard bench: default instance plus a penalty / 2-bit score one.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_lane_input_judge;

  localparam int N = 4;
  localparam int W = 16;

  logic       clock     = 1'b0;
  logic       resetn    = 1'b1;
  logic       go        = 1'b0;
  logic [3:0] key_n     = 4'hF;
  logic [2:0] line_code = 3'd0;

  logic       a_done, a_cor, a_inc, a_miss;
  logic [7:0] a_hit, a_str;
  logic       b_done, b_cor, b_inc, b_miss;
  logic [1:0] b_hit, b_str;

  typedef struct {
    int a_c, a_i, a_m, a_hit, a_str;
    int b_c, b_i, b_m, b_hit, b_str;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   m_a_hit  = 0;
  int   m_a_str  = 0;
  int   m_b_hit  = 0;
  int   m_b_str  = 0;

  lane_input_judge u_dut_a (
    .clock(clock), .resetn(resetn), .check_input_go(go), .key_n(key_n),
    .line_code(line_code), .check_input_done(a_done), .correct(a_cor),
    .incorrect(a_inc), .miss(a_miss), .hit_count(a_hit), .streak(a_str)
  );

  lane_input_judge #(.EMPTY_PENALTY(1), .SCORE_W(2)) u_dut_b (
    .clock(clock), .resetn(resetn), .check_input_go(go), .key_n(key_n),
    .line_code(line_code), .check_input_done(b_done), .correct(b_cor),
    .incorrect(b_inc), .miss(b_miss), .hit_count(b_hit), .streak(b_str)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic predict_push(input int code, input int mask, input bit has_press, input int d);
    exp_t e;
    int   tgt;
    bit   b_pen;
    tgt   = (code >= 1 && code <= N) ? (1 << (N - code)) : 0;
    e     = '{default: 0};
    b_pen = 1'b0;
    if (has_press) begin
      if (tgt != 0) begin
        if ((mask & ~tgt) != 0) e.a_i = 1;
        else                    e.a_c = 1;
      end else begin
        b_pen = 1'b1;
      end
    end else if (tgt != 0) begin
      e.a_m = 1;
    end
    e.b_c = e.a_c;
    e.b_m = e.a_m;
    e.b_i = e.a_i | int'(b_pen);
    if (e.a_c != 0) begin
      m_a_hit = sat_inc(m_a_hit, 255);
      m_a_str = sat_inc(m_a_str, 255);
    end else if (e.a_i != 0 || e.a_m != 0) begin
      m_a_str = 0;
    end
    if (e.b_c != 0) begin
      m_b_hit = sat_inc(m_b_hit, 3);
      m_b_str = sat_inc(m_b_str, 3);
    end else if (e.b_i != 0 || e.b_m != 0) begin
      m_b_str = 0;
    end
    e.a_hit = m_a_hit;
    e.a_str = m_a_str;
    e.b_hit = m_b_hit;
    e.b_str = m_b_str;
    e.lat   = has_press ? d + 4 : W + 2;
    sb.push_back(e);
  endtask

  task automatic run_check(input string tag, input int code, input int mask,
                           input bit has_press, input int d);
    int   cyc;
    bit   got;
    exp_t e;
    @(posedge clock);
    #1;
    line_code = 3'(code);
    go        = 1'b1;
    predict_push(code, mask, has_press, d);
    @(posedge clock);
    cyc = 0;
    got = 1'b0;
    while (1) begin
      #1;
      if (has_press && cyc == d) key_n = key_n & ~4'(mask);
      if (a_done) begin
        got = 1'b1;
        break;
      end
      if (cyc >= W + 8) break;
      @(posedge clock);
      cyc++;
    end
    e = sb.pop_front();
    check_value({tag, "_done"}, int'(got), 1);
    if (got) begin
      check_value({tag, "_lat"},   cyc, e.lat);
      check_value({tag, "_a_flags"}, {a_cor, a_inc, a_miss}, (e.a_c << 2) | (e.a_i << 1) | e.a_m);
      check_value({tag, "_b_flags"}, {b_done, b_cor, b_inc, b_miss},
                  8 | (e.b_c << 2) | (e.b_i << 1) | e.b_m);
      check_value({tag, "_a_hit"}, a_hit, e.a_hit);
      check_value({tag, "_a_str"}, a_str, e.a_str);
      check_value({tag, "_b_hit"}, b_hit, e.b_hit);
      check_value({tag, "_b_str"}, b_str, e.b_str);
    end
    go = 1'b0;
    @(posedge clock);
    #1;
    check_value({tag, "_drop"},
                {a_done, a_cor, a_inc, a_miss, b_done, b_cor, b_inc, b_miss}, 0);
    check_value({tag, "_keep"}, {a_hit, a_str, b_hit, b_str},
                (e.a_hit << 12) | (e.a_str << 4) | (e.b_hit << 2) | e.b_str);
    key_n = 4'hF;
    repeat (4) @(posedge clock);
  endtask

  initial begin
    bit seen;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_value("reset_a", {a_done, a_cor, a_inc, a_miss, a_hit, a_str}, 0);
    check_value("reset_b", {b_done, b_cor, b_inc, b_miss, b_hit, b_str}, 0);
    resetn = 1'b1;
    repeat (2) @(posedge clock);

    run_check("hit_l2",     2, 4'b0100, 1'b1, 5);
    run_check("two_keys",   1, 4'b1001, 1'b1, 3);
    run_check("miss_l4",    4, 4'b0000, 1'b0, 0);
    key_n[1] = 1'b0;
    repeat (4) @(posedge clock);
    run_check("held_l3",    3, 4'b0010, 1'b0, 0);
    run_check("empty_row",  0, 4'b0100, 1'b1, 2);
    run_check("seq_l1",     1, 4'b1000, 1'b1, 0);
    run_check("seq_l2",     2, 4'b0100, 1'b1, 7);
    run_check("seq_l3",     3, 4'b0010, 1'b1, 1);
    run_check("seq_l4",     4, 4'b0001, 1'b1, 10);
    run_check("bad_code",   5, 4'b0001, 1'b1, 0);
    run_check("last_cycle", 2, 4'b0100, 1'b1, W - 2);

    // Abandon a check mid-window with an asynchronous reset.
    @(posedge clock);
    #1;
    line_code = 3'd2;
    go        = 1'b1;
    repeat (6) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check_value("midrst_a", {a_done, a_cor, a_inc, a_miss, a_hit, a_str}, 0);
    check_value("midrst_b", {b_done, b_cor, b_inc, b_miss, b_hit, b_str}, 0);
    m_a_hit = 0;
    m_a_str = 0;
    m_b_hit = 0;
    m_b_str = 0;
    go = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    seen   = 1'b0;
    repeat (W + 4) begin
      @(posedge clock);
      #1;
      if (a_done || b_done) seen = 1'b1;
    end
    check_value("midrst_nodone", int'(seen), 0);
    run_check("post_rst", 1, 4'b1000, 1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lane_input_judge.md
LANE_INPUT_JUDGE -- requirements
Module: lane_input_judge

Interface
REQ-001 Parameter NUM_LANES, default 4: number of lanes and keys (2..8).
REQ-002 Parameter CODE_W, default 3: width of the lane code; 2**CODE_W SHALL exceed NUM_LANES.
REQ-003 Parameter WINDOW_CYCLES, default 16: length of the judging window in clock cycles (>=2).
REQ-004 Parameter SCORE_W, default 8: width of the hit and streak counters.
REQ-005 Parameter EMPTY_PENALTY, default 0: when 1, a press during an empty-row window is judged incorrect.
REQ-006 clock  in  1  single system clock; all state SHALL be on its rising edge.
REQ-007 resetn  in  1  asynchronous, active-low reset.
REQ-008 check_input_go  in  1  level request; held high by the controller until it has consumed the result.
REQ-009 key_n  in  NUM_LANES  raw active-low push keys, asynchronous to clock.
REQ-010 line_code  in  CODE_W  target lane: 0 = empty row; k in 1..NUM_LANES = lane k; other values = empty row.
REQ-011 check_input_done  out  1  result valid.
REQ-012 correct  out  1  target lane pressed.
REQ-013 incorrect  out  1  wrong lane pressed.
REQ-014 miss  out  1  non-empty target with no press before the window expired.
REQ-015 hit_count  out  SCORE_W  saturating count of correct results.
REQ-016 streak  out  SCORE_W  saturating count of consecutive correct results.

Function
REQ-017 Lane k SHALL map to key_n[NUM_LANES-k], so code 1 is the most-significant key.
REQ-018 Each key_n bit SHALL pass through a 2-flop synchroniser; a press event is a 1->0 transition of the synchronised value.
REQ-019 A key already held low when a window opens SHALL NOT generate a press event.
REQ-020 The FSM SHALL have the states IDLE, ARM, WINDOW and DONE.
REQ-021 IDLE -> ARM on a clock edge where go=1; line_code SHALL be latched on that edge, and the window counter SHALL clear to 0.
REQ-022 ARM -> WINDOW after exactly one cycle; this cycle SHALL sample the previous synchroniser value so that no edge is lost or invented.
REQ-023 In WINDOW, the counter SHALL increment by 1 per cycle; the judgement SHALL be taken on the first cycle that has any press event, or on the cycle where counter = WINDOW_CYCLES-1.
REQ-024 Judgement, target non-empty: a press on the target lane only sets correct=1; a press on any other lane sets incorrect=1, including when the target lane is pressed in the same cycle; expiry with no press sets miss=1.
REQ-025 Judgement, target empty: a press sets incorrect=1 if EMPTY_PENALTY=1; otherwise, and on expiry, all three flags SHALL be 0.
REQ-026 The judgement cycle SHALL transition to DONE; in DONE, check_input_done=1 and the flags SHALL hold stable. At most one of correct, incorrect and miss SHALL be 1.
REQ-027 Worst-case latency from go sampled to done SHALL be WINDOW_CYCLES+2 cycles; the minimum SHALL be 3 cycles.
REQ-028 On entering DONE with correct=1, hit_count and streak SHALL each increment by 1, saturating at all-ones.
REQ-029 On entering DONE with incorrect=1 or miss=1, streak SHALL clear to 0.
REQ-030 An empty-row result with no flag set SHALL leave both counters unchanged.
REQ-031 go=0 in any state SHALL return the FSM to IDLE on the next edge and clear done and all flags; the counters SHALL be retained.
REQ-032 DONE -> IDLE only when go=0; a new check SHALL require go to drop for at least one cycle.

Reset
REQ-033 resetn=0 SHALL immediately force state IDLE, the window counter to 0, done/correct/incorrect/miss to 0, hit_count and streak to 0, and all synchroniser flops to 1 (released).
REQ-034 Reset asserted mid-window SHALL abandon the check with no counter update; after release, the block SHALL wait for go in IDLE.

Verification
REQ-035 Defaults, line_code=2, go high, key_n[2] pressed 5 cycles after go -> correct=1, done=1, hit_count=1, streak=1, incorrect=0, miss=0.
REQ-036 line_code=1, key_n[3] and key_n[0] pressed in the same cycle -> incorrect=1, correct=0, streak=0, hit_count unchanged.
REQ-037 line_code=4, no press -> miss=1 and done exactly 18 cycles after go was sampled; then go low -> all flags 0 on the next edge.
REQ-038 line_code=3, key_n[1] held low before go and never released -> miss=1 (no press event).
REQ-039 line_code=0 with a press on key_n[2]: EMPTY_PENALTY=0 -> done=1 with all flags 0; EMPTY_PENALTY=1 -> incorrect=1.
REQ-040 SCORE_W=2, four consecutive correct checks -> hit_count=3 and streak=3 (saturated); resetn pulsed low mid-window -> all outputs 0 at once and no done.
